// File: rtl/lsu_ecc_scrub.sv
// ---------------------------------------------------------------------------
// lsu_ecc_scrub
//
// Correction-writeback stage behind the DCCM ECC check/merge stage. Loads
// that saw a single-bit (SEC) error in dc3 have their corrected bank line(s)
// captured into a small FIFO. A two-state drain FSM writes each line back to
// the DCCM through a req/gnt port together with freshly encoded ECC, so the
// latent error in the array is scrubbed. A saturating SEC event counter with
// a sticky threshold flag is kept alongside.
//
// Ports
//   clk, rst_l                       clock, asynchronous active-low reset
//   cap_en_dc3                       dc3 load eligible for capture
//   single_ecc_error_hi/lo_dc3       SEC seen on hi / lo bank
//   double_ecc_error_dc3             DED on either bank (suppresses capture)
//   lsu_addr_dc3, end_addr_dc3       start / end byte address of the access
//   store_ecc_datafn_hi/lo_dc3       corrected bank data
//   dccm_wr_en_any, dccm_wr_addr_any competing DCCM write (store drain)
//   scrub_wr_gnt                     write port granted
//   scrub_wr_req/addr/data/ecc       scrub write request and payload
//   scrub_full                       fewer than 2 free FIFO entries
//   scrub_busy                       FIFO non-empty
//   scrub_ovf                        sticky: a capture was dropped
//   sec_count                        saturating SEC event count
//   sec_thresh                       count threshold (0 disables)
//   sec_thresh_hit                   sticky: sec_count reached sec_thresh
//   sec_clr                          clears sec_count, sec_thresh_hit, scrub_ovf
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// rvecc_encode_64
//
// Combinational SEC-DED encoder. The low ECC_WIDTH-1 bits are Hamming check
// bits: data bits occupy the non-power-of-two codeword positions in order and
// check bit k covers every position with bit k set. The top bit is overall
// parity over data and check bits.
//
// Ports
//   din      data word
//   ecc_out  check bits {overall_parity, hamming[ECC_WIDTH-2:0]}
// ---------------------------------------------------------------------------
module rvecc_encode_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int ECC_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] din,
    output logic [ECC_WIDTH-1:0]  ecc_out
);

    localparam int K = ECC_WIDTH - 1;

    // Data-bit coverage mask of Hamming check bit k, evaluated at elaboration.
    function automatic logic [DATA_WIDTH-1:0] f_mask(input int k);
        logic [DATA_WIDTH-1:0] m;
        int d;
        m = '0;
        d = 0;
        for (int pos = 1; pos < (1 << K); pos++) begin
            if (((pos & (pos - 1)) != 0) && (d < DATA_WIDTH)) begin
                if (((pos >> k) & 1) != 0) begin
                    m = m | (DATA_WIDTH'(1) << d);
                end
                d++;
            end
        end
        return m;
    endfunction

    logic [K-1:0] w_chk;

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_chk
            localparam logic [DATA_WIDTH-1:0] MASK = f_mask(gi);
            assign w_chk[gi] = ^(din & MASK);
        end
    endgenerate

    assign ecc_out = {^{din, w_chk}, w_chk};

endmodule

module lsu_ecc_scrub #(
    parameter int DATA_WIDTH = 64,
    parameter int ECC_WIDTH  = 8,
    parameter int ADDR_BITS  = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  cap_en_dc3,
    input  logic                  single_ecc_error_hi_dc3,
    input  logic                  single_ecc_error_lo_dc3,
    input  logic                  double_ecc_error_dc3,
    input  logic [ADDR_BITS-1:0]  lsu_addr_dc3,
    input  logic [ADDR_BITS-1:0]  end_addr_dc3,
    input  logic [DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
    input  logic [DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
    input  logic                  dccm_wr_en_any,
    input  logic [ADDR_BITS-1:0]  dccm_wr_addr_any,
    input  logic                  scrub_wr_gnt,
    output logic                  scrub_wr_req,
    output logic [ADDR_BITS-1:0]  scrub_wr_addr,
    output logic [DATA_WIDTH-1:0] scrub_wr_data,
    output logic [ECC_WIDTH-1:0]  scrub_wr_ecc,
    output logic                  scrub_full,
    output logic                  scrub_busy,
    output logic                  scrub_ovf,
    output logic [CNT_WIDTH-1:0]  sec_count,
    input  logic [CNT_WIDTH-1:0]  sec_thresh,
    output logic                  sec_thresh_hit,
    input  logic                  sec_clr
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;
    localparam int LINE_W = ADDR_BITS - 3;
    localparam int SUM_W  = CNT_WIDTH + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    // ---------------------------------------------------------------- state
    state_t                r_state;
    logic                  r_wr_req;
    logic [DEPTH-1:0]      r_valid;
    logic [LINE_W-1:0]     r_line [DEPTH];   // 8-byte line address only
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [OCC_W-1:0]      r_count;
    logic                  r_ovf;
    logic                  r_thresh_hit;
    logic [CNT_WIDTH-1:0]  r_sec_count;

    // ---------------------------------------------------------------- wires
    logic                  w_qual;
    logic                  w_push_lo;
    logic                  w_push_hi;
    logic                  w_acc_lo;
    logic                  w_acc_hi;
    logic                  w_drop;
    logic                  w_pop;
    logic [LINE_W-1:0]     w_lo_line;
    logic [LINE_W-1:0]     w_hi_line;
    logic [LINE_W-1:0]     w_wr_line;
    logic                  w_lo_hit;
    logic                  w_hi_hit;
    logic [OCC_W-1:0]      w_free;
    logic [OCC_W-1:0]      w_count_next;
    logic [PTR_W-1:0]      w_lo_slot;
    logic [PTR_W-1:0]      w_hi_slot;
    logic [PTR_W-1:0]      w_rd_ptr_next;
    logic [PTR_W-1:0]      w_wr_ptr_next;
    logic [DEPTH-1:0]      w_line_hit;
    logic [DEPTH-1:0]      w_valid_next;
    logic                  w_head_ok_next;
    logic [1:0]            w_sec_inc;
    logic [SUM_W-1:0]      w_sec_sum;
    logic [CNT_WIDTH-1:0]  w_sec_sat;
    logic                  w_unused_bits;

    // Byte offsets only matter for the bank-crossing test on bit 3.
    assign w_unused_bits = ^{lsu_addr_dc3[2:0], end_addr_dc3[2:0], dccm_wr_addr_any[2:0]};

    // ---------------------------------------------------------------- push
    assign w_qual    = cap_en_dc3 & ~double_ecc_error_dc3;
    assign w_push_lo = w_qual & single_ecc_error_lo_dc3;
    // The hi bank is only part of the access when start and end fall in
    // different 8-byte lines.
    assign w_push_hi = w_qual & single_ecc_error_hi_dc3 & (lsu_addr_dc3[3] ^ end_addr_dc3[3]);

    assign w_lo_line = lsu_addr_dc3[ADDR_BITS-1:3];
    assign w_hi_line = end_addr_dc3[ADDR_BITS-1:3];
    assign w_wr_line = dccm_wr_addr_any[ADDR_BITS-1:3];

    // A store drain to the same line makes the captured copy stale.
    assign w_lo_hit = dccm_wr_en_any & (w_lo_line == w_wr_line);
    assign w_hi_hit = dccm_wr_en_any & (w_hi_line == w_wr_line);

    // Free space is taken from registered occupancy; a same-cycle pop does
    // not make room for a same-cycle push. lo is always offered first.
    assign w_free   = OCC_W'(DEPTH) - r_count;
    assign w_acc_lo = w_push_lo & (w_free != '0);
    assign w_acc_hi = w_push_hi & (w_free > OCC_W'(w_acc_lo));
    assign w_drop   = (w_push_lo & ~w_acc_lo) | (w_push_hi & ~w_acc_hi);

    assign w_lo_slot = r_wr_ptr;
    assign w_hi_slot = r_wr_ptr + PTR_W'(w_acc_lo);

    // ---------------------------------------------------------------- pop
    // REQ pops on grant; IDLE silently discards an invalidated head.
    assign w_pop = (r_state == S_REQ) ? scrub_wr_gnt
                                      : ((r_count != '0) & ~r_valid[r_rd_ptr]);

    assign w_wr_ptr_next = r_wr_ptr + PTR_W'(w_acc_lo) + PTR_W'(w_acc_hi);
    assign w_rd_ptr_next = r_rd_ptr + PTR_W'(w_pop);
    assign w_count_next  = r_count + OCC_W'(w_acc_lo) + OCC_W'(w_acc_hi) - OCC_W'(w_pop);

    // ---------------------------------------------------------------- entry valid
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic w_v_nxt;

            assign w_line_hit[gi] = dccm_wr_en_any & (r_line[gi] == w_wr_line);

            always_comb begin
                w_v_nxt = r_valid[gi];
                if (w_pop && (r_rd_ptr == PTR_W'(gi))) begin
                    w_v_nxt = 1'b0;
                end
                if (w_line_hit[gi]) begin
                    w_v_nxt = 1'b0;
                end
                if (w_acc_lo && (w_lo_slot == PTR_W'(gi))) begin
                    w_v_nxt = ~w_lo_hit;
                end
                if (w_acc_hi && (w_hi_slot == PTR_W'(gi))) begin
                    w_v_nxt = ~w_hi_hit;
                end
            end

            assign w_valid_next[gi] = w_v_nxt;
        end
    endgenerate

    // Request for the next cycle is decided from the post-update head so a
    // capture in cycle N is already requesting in N+1, and an invalidated
    // head drops the request one cycle after the hazard.
    assign w_head_ok_next = (w_count_next != '0) & w_valid_next[w_rd_ptr_next];

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_valid  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_line[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_valid  <= w_valid_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_count  <= w_count_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_acc_lo && (w_lo_slot == PTR_W'(i))) begin
                    r_line[i] <= w_lo_line;
                    r_data[i] <= store_ecc_datafn_lo_dc3;
                end else if (w_acc_hi && (w_hi_slot == PTR_W'(i))) begin
                    r_line[i] <= w_hi_line;
                    r_data[i] <= store_ecc_datafn_hi_dc3;
                end
            end
        end
    end

    // ---------------------------------------------------------------- drain FSM
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state  <= S_IDLE;
            r_wr_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_head_ok_next) begin
                        r_state  <= S_REQ;
                        r_wr_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!w_head_ok_next) begin
                        r_state  <= S_IDLE;
                        r_wr_req <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_wr_req <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- SEC counter
    assign w_sec_inc = {1'b0, w_push_lo} + {1'b0, w_push_hi};
    assign w_sec_sum = {1'b0, r_sec_count} + SUM_W'(w_sec_inc);
    assign w_sec_sat = w_sec_sum[CNT_WIDTH] ? '1 : w_sec_sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sec_count  <= '0;
            r_thresh_hit <= 1'b0;
            r_ovf        <= 1'b0;
        end else if (sec_clr) begin
            r_sec_count  <= '0;
            r_thresh_hit <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_sec_count <= w_sec_sat;
            if ((sec_thresh != '0) && (w_sec_sat >= sec_thresh)) begin
                r_thresh_hit <= 1'b1;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign scrub_wr_req  = r_wr_req;
    assign scrub_wr_addr = r_wr_req ? {r_line[r_rd_ptr], 3'b000} : '0;
    assign scrub_wr_data = r_wr_req ? r_data[r_rd_ptr] : '0;

    rvecc_encode_64 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ECC_WIDTH  (ECC_WIDTH)
    ) u_enc (
        .din     (scrub_wr_data),
        .ecc_out (scrub_wr_ecc)
    );

    assign scrub_full     = (r_count >= OCC_W'(DEPTH - 1));
    assign scrub_busy     = (r_count != '0);
    assign scrub_ovf      = r_ovf;
    assign sec_count      = r_sec_count;
    assign sec_thresh_hit = r_thresh_hit;

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// ---------------------------------------------------------------------------
// tb_lsu_ecc_scrub
//
// Directed bench for lsu_ecc_scrub: capture latency, dual-bank ordering,
// grant stall, store-drain invalidation, overflow, SEC threshold, counter
// saturation and asynchronous reset mid-request. Expected ECC comes from an
// independent position-XOR Hamming model.
// ---------------------------------------------------------------------------
module tb_lsu_ecc_scrub;

    localparam int DW  = 64;
    localparam int EW  = 8;
    localparam int AW  = 16;
    localparam int DEP = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          cap_en_dc3;
    logic          single_ecc_error_hi_dc3;
    logic          single_ecc_error_lo_dc3;
    logic          double_ecc_error_dc3;
    logic [AW-1:0] lsu_addr_dc3;
    logic [AW-1:0] end_addr_dc3;
    logic [DW-1:0] store_ecc_datafn_hi_dc3;
    logic [DW-1:0] store_ecc_datafn_lo_dc3;
    logic          dccm_wr_en_any;
    logic [AW-1:0] dccm_wr_addr_any;
    logic          scrub_wr_gnt;
    logic          scrub_wr_req;
    logic [AW-1:0] scrub_wr_addr;
    logic [DW-1:0] scrub_wr_data;
    logic [EW-1:0] scrub_wr_ecc;
    logic          scrub_full;
    logic          scrub_busy;
    logic          scrub_ovf;
    logic [CW-1:0] sec_count;
    logic [CW-1:0] sec_thresh;
    logic          sec_thresh_hit;
    logic          sec_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu_ecc_scrub #(
        .DATA_WIDTH (DW),
        .ECC_WIDTH  (EW),
        .ADDR_BITS  (AW),
        .DEPTH      (DEP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                     (clk),
        .rst_l                   (rst_l),
        .cap_en_dc3              (cap_en_dc3),
        .single_ecc_error_hi_dc3 (single_ecc_error_hi_dc3),
        .single_ecc_error_lo_dc3 (single_ecc_error_lo_dc3),
        .double_ecc_error_dc3    (double_ecc_error_dc3),
        .lsu_addr_dc3            (lsu_addr_dc3),
        .end_addr_dc3            (end_addr_dc3),
        .store_ecc_datafn_hi_dc3 (store_ecc_datafn_hi_dc3),
        .store_ecc_datafn_lo_dc3 (store_ecc_datafn_lo_dc3),
        .dccm_wr_en_any          (dccm_wr_en_any),
        .dccm_wr_addr_any        (dccm_wr_addr_any),
        .scrub_wr_gnt            (scrub_wr_gnt),
        .scrub_wr_req            (scrub_wr_req),
        .scrub_wr_addr           (scrub_wr_addr),
        .scrub_wr_data           (scrub_wr_data),
        .scrub_wr_ecc            (scrub_wr_ecc),
        .scrub_full              (scrub_full),
        .scrub_busy              (scrub_busy),
        .scrub_ovf               (scrub_ovf),
        .sec_count               (sec_count),
        .sec_thresh              (sec_thresh),
        .sec_thresh_hit          (sec_thresh_hit),
        .sec_clr                 (sec_clr)
    );

    // Hamming syndrome of a word = XOR of the codeword positions of its set
    // data bits; overall parity covers data plus check bits.
    function automatic logic [7:0] exp_ecc(input logic [63:0] d);
        logic [6:0] syn;
        int di;
        syn = '0;
        di  = 0;
        for (int pos = 3; pos < 128; pos++) begin
            if (((pos & (pos - 1)) != 0) && (di < 64)) begin
                if (((d >> di) & 64'd1) != 64'd0) begin
                    syn = syn ^ 7'(pos);
                end
                di++;
            end
        end
        return {(^d) ^ (^syn), syn};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cap_en_dc3              = 1'b0;
        single_ecc_error_hi_dc3 = 1'b0;
        single_ecc_error_lo_dc3 = 1'b0;
        double_ecc_error_dc3    = 1'b0;
        dccm_wr_en_any          = 1'b0;
        sec_clr                 = 1'b0;
    endtask

    task automatic cap(input logic lo, input logic hi, input logic [AW-1:0] a,
                       input logic [AW-1:0] e, input logic [DW-1:0] dlo,
                       input logic [DW-1:0] dhi);
        cap_en_dc3              = 1'b1;
        single_ecc_error_lo_dc3 = lo;
        single_ecc_error_hi_dc3 = hi;
        lsu_addr_dc3            = a;
        end_addr_dc3            = e;
        store_ecc_datafn_lo_dc3 = dlo;
        store_ecc_datafn_hi_dc3 = dhi;
    endtask

    task automatic clear_stats();
        sec_clr = 1'b1;
        tick();
        idle_in();
    endtask

    initial begin
        logic [DW-1:0] da;
        logic [DW-1:0] db;

        rst_l            = 1'b0;
        scrub_wr_gnt     = 1'b0;
        sec_thresh       = '0;
        lsu_addr_dc3     = '0;
        end_addr_dc3     = '0;
        dccm_wr_addr_any = '0;
        store_ecc_datafn_hi_dc3 = '0;
        store_ecc_datafn_lo_dc3 = '0;
        idle_in();

        // ---- reset state
        repeat (3) tick();
        chk("rst_req",   scrub_wr_req, 0);
        chk("rst_busy",  scrub_busy, 0);
        chk("rst_full",  scrub_full, 0);
        chk("rst_ovf",   scrub_ovf, 0);
        chk("rst_hit",   sec_thresh_hit, 0);
        chk("rst_count", sec_count, 0);
        chk("rst_addr",  scrub_wr_addr, 0);
        chk("rst_data",  scrub_wr_data, 0);
        chk("rst_ecc",   scrub_wr_ecc, 0);
        rst_l = 1'b1;
        tick();

        // ---- single lo SEC, gnt tied high
        scrub_wr_gnt = 1'b1;
        da = 64'hDEADBEEF_00000001;
        cap(1'b1, 1'b0, 16'h0104, 16'h0104, da, 64'h0);
        tick();
        idle_in();
        chk("t1_req",   scrub_wr_req, 1);
        chk("t1_addr",  scrub_wr_addr, 16'h0100);
        chk("t1_data",  scrub_wr_data, da);
        chk("t1_ecc",   scrub_wr_ecc, exp_ecc(da));
        chk("t1_busy",  scrub_busy, 1);
        chk("t1_count", sec_count, 1);
        tick();
        chk("t1_busy_done", scrub_busy, 0);
        chk("t1_req_done",  scrub_wr_req, 0);
        chk("t1_addr_idle", scrub_wr_addr, 0);

        // ---- dual-bank SEC: lo line then hi line in consecutive cycles
        clear_stats();
        chk("t2_clr_count", sec_count, 0);
        da = 64'h01234567_89ABCDEF;
        db = 64'hFEDCBA98_76543210;
        cap(1'b1, 1'b1, 16'h0006, 16'h000D, da, db);
        tick();
        idle_in();
        chk("t2_req0",  scrub_wr_req, 1);
        chk("t2_addr0", scrub_wr_addr, 16'h0000);
        chk("t2_data0", scrub_wr_data, da);
        chk("t2_ecc0",  scrub_wr_ecc, exp_ecc(da));
        chk("t2_count", sec_count, 2);
        tick();
        chk("t2_req1",  scrub_wr_req, 1);
        chk("t2_addr1", scrub_wr_addr, 16'h0008);
        chk("t2_data1", scrub_wr_data, db);
        chk("t2_ecc1",  scrub_wr_ecc, exp_ecc(db));
        tick();
        chk("t2_busy_done", scrub_busy, 0);

        // ---- DED suppresses capture and counting
        cap(1'b1, 1'b0, 16'h0010, 16'h0010, da, db);
        double_ecc_error_dc3 = 1'b1;
        tick();
        idle_in();
        chk("t_ded_busy",  scrub_busy, 0);
        chk("t_ded_count", sec_count, 2);

        // ---- grant withheld for 5 cycles
        scrub_wr_gnt = 1'b0;
        da = 64'h5555AAAA_0F0FF0F0;
        cap(1'b1, 1'b0, 16'h0300, 16'h0300, da, 64'h0);
        tick();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            chk("t3_req_hold",  scrub_wr_req, 1);
            chk("t3_addr_hold", scrub_wr_addr, 16'h0300);
            chk("t3_data_hold", scrub_wr_data, da);
            tick();
        end
        chk("t3_req_still", scrub_wr_req, 1);
        scrub_wr_gnt = 1'b1;
        tick();
        scrub_wr_gnt = 1'b0;
        chk("t3_busy_pop", scrub_busy, 0);
        chk("t3_req_pop",  scrub_wr_req, 0);

        // ---- store-drain hazard on a queued entry
        cap(1'b1, 1'b0, 16'h0200, 16'h0200, 64'h1111, 64'h0);
        tick();
        idle_in();
        chk("t4_req", scrub_wr_req, 1);
        dccm_wr_en_any   = 1'b1;
        dccm_wr_addr_any = 16'h0208;
        tick();
        dccm_wr_en_any = 1'b0;
        chk("t4_other_line_req",  scrub_wr_req, 1);
        chk("t4_other_line_addr", scrub_wr_addr, 16'h0200);
        dccm_wr_en_any   = 1'b1;
        dccm_wr_addr_any = 16'h0204;
        tick();
        dccm_wr_en_any = 1'b0;
        chk("t4_req_drop",  scrub_wr_req, 0);
        chk("t4_busy_stale", scrub_busy, 1);
        tick();
        chk("t4_busy_empty", scrub_busy, 0);
        chk("t4_req_empty",  scrub_wr_req, 0);

        // ---- hazard in the same cycle as the push
        cap(1'b1, 1'b0, 16'h0400, 16'h0400, 64'h2222, 64'h0);
        dccm_wr_en_any   = 1'b1;
        dccm_wr_addr_any = 16'h0407;
        tick();
        idle_in();
        chk("t4b_req",  scrub_wr_req, 0);
        chk("t4b_busy", scrub_busy, 1);
        tick();
        chk("t4b_busy_empty", scrub_busy, 0);

        // ---- fill to overflow with grant low
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            cap(1'b1, 1'b0, 16'(16'h1000 + 8 * i), 16'(16'h1000 + 8 * i),
                64'(64'hA000 + i), 64'h0);
            tick();
            idle_in();
            chk("t5_full",  scrub_full, (i >= 2) ? 1 : 0);
            chk("t5_ovf",   scrub_ovf, (i == 4) ? 1 : 0);
            chk("t5_count", sec_count, i + 1);
        end
        scrub_wr_gnt = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("t5_drain_addr", scrub_wr_addr, 16'(16'h1000 + 8 * j));
            chk("t5_drain_data", scrub_wr_data, 64'(64'hA000 + j));
            tick();
        end
        scrub_wr_gnt = 1'b0;
        chk("t5_busy_empty", scrub_busy, 0);
        chk("t5_ovf_sticky", scrub_ovf, 1);
        clear_stats();
        chk("t5_ovf_clr", scrub_ovf, 0);

        // ---- two pushes with one free slot: lo kept, hi dropped
        for (int i = 0; i < 3; i++) begin
            cap(1'b1, 1'b0, 16'(16'h2000 + 8 * i), 16'(16'h2000 + 8 * i), 64'h0, 64'h0);
            tick();
            idle_in();
        end
        chk("t5b_ovf_pre", scrub_ovf, 0);
        cap(1'b1, 1'b1, 16'h2020, 16'h2028, 64'hBEEF, 64'hCAFE);
        tick();
        idle_in();
        chk("t5b_ovf",   scrub_ovf, 1);
        chk("t5b_count", sec_count, 5);
        scrub_wr_gnt = 1'b1;
        chk("t5b_addr0", scrub_wr_addr, 16'h2000);
        tick();
        chk("t5b_addr1", scrub_wr_addr, 16'h2008);
        tick();
        chk("t5b_addr2", scrub_wr_addr, 16'h2010);
        tick();
        chk("t5b_addr3", scrub_wr_addr, 16'h2020);
        chk("t5b_data3", scrub_wr_data, 64'hBEEF);
        tick();
        chk("t5b_busy_empty", scrub_busy, 0);

        // ---- threshold and clear priority
        clear_stats();
        sec_thresh = 4'd3;
        for (int i = 0; i < 3; i++) begin
            cap(1'b1, 1'b0, 16'(16'h3000 + 8 * i), 16'(16'h3000 + 8 * i), 64'h7, 64'h0);
            tick();
            idle_in();
            chk("t6_count", sec_count, i + 1);
            chk("t6_hit",   sec_thresh_hit, (i == 2) ? 1 : 0);
        end
        tick();
        chk("t6_hit_sticky", sec_thresh_hit, 1);
        chk("t6_count_hold", sec_count, 3);
        cap(1'b1, 1'b0, 16'h3100, 16'h3100, 64'h8, 64'h0);
        sec_clr = 1'b1;
        tick();
        idle_in();
        chk("t6_clr_count", sec_count, 0);
        chk("t6_clr_hit",   sec_thresh_hit, 0);
        sec_thresh = '0;

        // ---- saturation, threshold disabled
        repeat (3) tick();
        clear_stats();
        for (int i = 0; i < 8; i++) begin
            cap(1'b1, 1'b1, 16'h4000, 16'h4008, 64'h1, 64'h2);
            tick();
            idle_in();
            chk("t7_count", sec_count, (2 * (i + 1) > 15) ? 15 : 2 * (i + 1));
        end
        chk("t7_hit_disabled", sec_thresh_hit, 0);
        repeat (6) tick();
        chk("t7_busy_empty", scrub_busy, 0);
        scrub_wr_gnt = 1'b0;

        // ---- asynchronous reset mid-request
        cap(1'b1, 1'b0, 16'h5000, 16'h5000, 64'h9, 64'h0);
        tick();
        idle_in();
        chk("t8_req", scrub_wr_req, 1);
        rst_l = 1'b0;
        #1;
        chk("t8_req_rst",   scrub_wr_req, 0);
        chk("t8_busy_rst",  scrub_busy, 0);
        chk("t8_count_rst", sec_count, 0);
        tick();
        rst_l = 1'b1;
        tick();
        chk("t8_req_after",  scrub_wr_req, 0);
        chk("t8_busy_after", scrub_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
